serial_parallel_rx: RTL
=======================

# serial_parallel_rx

Serial-to-parallel receiver for the lab 4 serial link: it recovers 10-bit frames from a single serial line and presents each received character to the CPU. A frame is an idle-high line, then a start bit (0), data bits d0..d7 LSB first, and a stop bit (1). It is the far-end counterpart of the parallel-to-serial transmitter and uses the same bit period, frame format and bit order. The CPU consumes characters with a level-valid / pulse-read handshake, and the block reports overrun and framing errors.

## Interface
- BIT_CYCLES, 16, clk cycles per serial bit; must be even and ≥ 4. HALF = BIT_CYCLES/2.
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- enable  input  1  receiver enable; low forces IDLE and discards any partial frame.
- in  input  1  serial line, asynchronous to clk, idle high.
- read  input  1  one-cycle pulse from CPU; acknowledges the current character.
- toCPU  output  8  last correctly received character.
- charReceived  output  1  level; high while toCPU holds an unread character.
- overrun  output  1  sticky; set when a character completes while charReceived is already high.
- framingError  output  1  one-cycle pulse when the stop bit samples 0.

## Operation
- **Synchronizer.** `in` passes through a 2-flop synchronizer (both flops reset to 1) to give in_s. The FSM and shift register use only in_s.
- **States.** IDLE, START, DATA, STOP. A bit counter counts 0..BIT_CYCLES-1 and a data index counts 0..7.
- **IDLE.** If enable=1 and in_s=0: go to START, counter=0.
- **START.** When counter reaches HALF-1 (mid start bit):
  - in_s=1: false start; return to IDLE.
  - in_s=0: go to DATA, counter=0, index=0.
- **DATA.** When counter reaches BIT_CYCLES-1:
  - shift in_s into bit[index] (LSB first) and reset the counter;
  - after index 7, go to STOP.
- **STOP.** When counter reaches BIT_CYCLES-1, return to IDLE. Then:
  - in_s=1: load toCPU with the shifted byte and set charReceived. If charReceived was already 1 and read is not asserted this cycle, also set overrun.
  - in_s=0: pulse framingError for one cycle. toCPU and charReceived are unchanged.
- **Re-arming.** From IDLE the FSM may detect the next start immediately; back-to-back frames need no idle bits.
- **read.**
  - read=1 with charReceived=1: clears charReceived and overrun on the next edge.
  - read=1 with charReceived=0: no effect.
  - read coincident with a good stop-bit sample: the new character wins. charReceived stays 1, toCPU takes the new byte, overrun is not set.
- **enable=0.**
  - Mid-frame: return to IDLE, clear counter and index, discard the partial byte.
  - toCPU, charReceived and overrun are kept.
  - The synchronizer keeps running.
- **Reset (any time, including mid-frame).** Immediate return to IDLE.
  - Reset values: toCPU=8'h00, charReceived=0, overrun=0, framingError=0, synchronizer=1, counter=0, index=0.

## Timing
- E0 is the first clk edge that samples `in` low into the synchronizer. The FSM sees in_s=0 at E2, and START is entered after E2.
- Each sample point k uses in_s at edge E0+2+HALF+k·BIT_CYCLES, which equals the line value at E0+HALF+k·BIT_CYCLES (mid-bit):
  - k=0: start bit.
  - k=1..8: d0..d7.
  - k=9: stop bit.
- charReceived rises and toCPU updates after edge E0+2+HALF+9·BIT_CYCLES. With BIT_CYCLES=16 this is edge E0+154.
- framingError is high for exactly the one cycle after the k=9 edge.
- A low glitch shorter than HALF cycles on an idle line produces no output activity.
- The start of the next frame can be detected one cycle after the k=9 edge.

## Test plan
- **Reset state.** Assert reset mid-frame → all outputs reach their reset values immediately. Deassert and idle for 200 cycles → no activity.
- **Single character.** enable=1, BIT_CYCLES=16, transmit 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) → toCPU=8'hA5 and charReceived=1 after edge E0+154. A read pulse then clears charReceived; toCPU stays A5.
- **False start.** 3-cycle low glitch on an idle line → FSM returns to IDLE, charReceived and framingError stay 0. A valid 0x3C frame afterwards is received correctly.
- **Framing error.** Frame 0x5A with stop bit 0 → framingError high for 1 cycle, charReceived=0, toCPU unchanged (00).
- **Overrun and read collision.**
  - Frames 0x11 then 0x22 back-to-back with no read → toCPU=22, charReceived=1, overrun=1. A read clears both flags.
  - Repeat with read asserted on the 0x22 stop-sample edge → overrun stays 0.
- **Enable drop.** Drop enable after d3 of frame 0xFF, raise it again, then send 0x81 → toCPU=81 only, with no spurious character or error.

Source files
------------

// File: rtl/serial_parallel_rx_if.sv
// serial_parallel_rx_if
// Groups the serial line, the receiver enable and the CPU character handshake
// of the serial-to-parallel receiver.
//   enable       : receiver enable (driven by the host side)
//   in           : serial line, idle high (driven by the line side)
//   read         : one-cycle character acknowledge from the CPU
//   toCPU        : last correctly received character
//   charReceived : high while toCPU holds an unread character
//   overrun      : sticky, a character completed while one was still unread
//   framingError : one-cycle pulse when a stop bit samples low
// The master modport is the line/CPU side, the slave modport is the receiver.
interface serial_parallel_rx_if;
  logic       enable;
  logic       in;
  logic       read;
  logic [7:0] toCPU;
  logic       charReceived;
  logic       overrun;
  logic       framingError;

  modport master (
    output enable,
    output in,
    output read,
    input  toCPU,
    input  charReceived,
    input  overrun,
    input  framingError
  );

  modport slave (
    input  enable,
    input  in,
    input  read,
    output toCPU,
    output charReceived,
    output overrun,
    output framingError
  );
endinterface

// File: rtl/serial_parallel_rx.sv
// serial_parallel_rx
// Recovers 10-bit frames (start 0, d0..d7 LSB first, stop 1) from an
// asynchronous serial line and hands each character to the CPU through a
// level-valid / pulse-read handshake, flagging overrun and framing errors.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; clears all state
//   rx    : serial_parallel_rx_if slave modport (enable, in, read in;
//           toCPU, charReceived, overrun, framingError out)
// Parameter BIT_CYCLES: clk cycles per serial bit, even and >= 4.
module serial_parallel_rx #(
  parameter int BIT_CYCLES = 16
) (
  input logic                 clk,
  input logic                 reset,
  serial_parallel_rx_if.slave rx
);

  localparam int HALF  = BIT_CYCLES / 2;
  localparam int CNT_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO      = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       idx_r;
  logic [7:0]       shift_r;
  logic [7:0]       to_cpu_r;
  logic             char_r;
  logic             overrun_r;
  logic             framing_r;
  logic             sync1_r;
  logic             sync2_r;
  logic             in_s;

  assign in_s = sync2_r;

  // Two-flop synchronizer for the asynchronous line; resets to the idle level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx.in;
      sync2_r <= sync1_r;
    end
  end

  // Frame FSM, bit timing, shift register and CPU-facing flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      idx_r     <= 3'd0;
      shift_r   <= 8'h00;
      to_cpu_r  <= 8'h00;
      char_r    <= 1'b0;
      overrun_r <= 1'b0;
      framing_r <= 1'b0;
    end else begin
      framing_r <= 1'b0;

      // A read only acknowledges a pending character. A character completing
      // on the same edge is assigned further down and therefore wins.
      if (rx.read && char_r) begin
        char_r    <= 1'b0;
        overrun_r <= 1'b0;
      end else begin
        char_r    <= char_r;
        overrun_r <= overrun_r;
      end

      if (!rx.enable) begin
        // Partial frame is discarded; delivered character and flags survive.
        state_r <= IDLE;
        cnt_r   <= CNT_ZERO;
        idx_r   <= 3'd0;
        shift_r <= 8'h00;
      end else begin
        case (state_r)
          IDLE: begin
            cnt_r <= CNT_ZERO;
            idx_r <= 3'd0;
            if (!in_s) begin
              state_r <= START;
            end else begin
              state_r <= IDLE;
            end
          end

          START: begin
            // Re-check the line at mid start bit to reject short glitches.
            if (cnt_r == CNT_HALF_LAST) begin
              cnt_r <= CNT_ZERO;
              idx_r <= 3'd0;
              if (in_s) begin
                state_r <= IDLE;
              end else begin
                state_r <= DATA;
              end
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end

          DATA: begin
            // Sampling is aligned mid-bit by the half-bit offset from START.
            if (cnt_r == CNT_BIT_LAST) begin
              cnt_r          <= CNT_ZERO;
              shift_r[idx_r] <= in_s;
              if (idx_r == 3'd7) begin
                idx_r   <= 3'd0;
                state_r <= STOP;
              end else begin
                idx_r <= idx_r + 3'd1;
              end
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end

          STOP: begin
            if (cnt_r == CNT_BIT_LAST) begin
              cnt_r   <= CNT_ZERO;
              state_r <= IDLE;
              if (in_s) begin
                to_cpu_r <= shift_r;
                char_r   <= 1'b1;
                if (char_r && !rx.read) begin
                  overrun_r <= 1'b1;
                end else begin
                  overrun_r <= overrun_r & ~(rx.read & char_r);
                end
              end else begin
                framing_r <= 1'b1;
              end
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end

          default: begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= 3'd0;
          end
        endcase
      end
    end
  end

  assign rx.toCPU        = to_cpu_r;
  assign rx.charReceived = char_r;
  assign rx.overrun      = overrun_r;
  assign rx.framingError = framing_r;

endmodule
